// File: rtl/jtag_scan_sequencer.sv
// ----------------------------------------------------------------------------
// jtag_scan_sequencer : JTAG TAP master turning IR/DR scan commands into pins
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtag_scan_sequencer #(
   parameter int TCK_DIV = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_kind,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        jtag_TCK,
   output logic        jtag_TMS,
   output logic        jtag_TDI,
   output logic        jtag_TRSTn,
   input  logic        jtag_TDO
);

   localparam logic [7:0] c_div_reload = 8'(TCK_DIV - 1);
   localparam logic [5:0] c_init_last  = 6'd6;

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_PRE   = 3'd2,
      S_SHIFT = 3'd3,
      S_POST  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t      r_state;
   logic [7:0]  r_div;
   logic        r_phase;
   logic [5:0]  r_step;
   logic [1:0]  r_kind;
   logic [4:0]  r_len;
   logic [31:0] r_data;
   logic [31:0] r_cap;
   logic        r_tck;
   logic        r_tms;
   logic        r_tdi;
   logic        r_trstn;
   logic        r_cmd_ready;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_data;

   logic        w_running;
   logic        w_rise;
   logic        w_fall;
   logic [5:0]  w_step_inc;
   logic [5:0]  w_len_ext;
   logic [5:0]  w_pre_last;
   logic [5:0]  w_pre_ones;

   always_comb begin
      w_running  = (r_state == S_INIT) || (r_state == S_PRE) ||
                   (r_state == S_SHIFT) || (r_state == S_POST);
      w_rise     = w_running && !r_phase && (r_div == 8'd0);
      w_fall     = w_running &&  r_phase && (r_div == 8'd0);
      w_step_inc = r_step + 6'd1;
      w_len_ext  = {1'b0, r_len};
      // PRE walk: leading TMS=1 steps, then TMS=0 steps up to the shift state
      case (r_kind)
         2'd0:    begin w_pre_last = 6'd2; w_pre_ones = 6'd1; end
         2'd1:    begin w_pre_last = 6'd3; w_pre_ones = 6'd2; end
         default: begin w_pre_last = 6'd5; w_pre_ones = 6'd5; end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_INIT;
         r_div       <= c_div_reload;
         r_phase     <= 1'b0;
         r_step      <= 6'd0;
         r_kind      <= 2'd0;
         r_len       <= 5'd0;
         r_data      <= 32'd0;
         r_cap       <= 32'd0;
         r_tck       <= 1'b0;
         r_tms       <= 1'b1;
         r_tdi       <= 1'b0;
         r_trstn     <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 32'd0;
      end else begin
         if (w_running && (r_div != 8'd0)) begin
            r_div <= r_div - 8'd1;
         end
         if (w_rise) begin
            r_phase <= 1'b1;
            r_div   <= c_div_reload;
            // INIT step 0 is the TRSTn hold: full step timing, TCK kept low
            if (!((r_state == S_INIT) && (r_step == 6'd0))) begin
               r_tck <= 1'b1;
            end
            if (r_state == S_SHIFT) begin
               r_cap[r_step[4:0]] <= jtag_TDO;
            end
         end
         if (w_fall) begin
            r_phase <= 1'b0;
            r_tck   <= 1'b0;
            r_div   <= c_div_reload;
         end

         case (r_state)
            S_INIT: begin
               if (w_fall) begin
                  if (r_step == c_init_last) begin
                     r_state     <= S_IDLE;
                     r_tms       <= 1'b0;
                     r_cmd_ready <= 1'b1;
                  end else begin
                     r_step  <= w_step_inc;
                     r_trstn <= 1'b1;
                     r_tms   <= (w_step_inc != c_init_last);
                  end
               end
            end
            S_IDLE: begin
               r_tms <= 1'b0;
               r_tdi <= 1'b0;
               if (cmd_valid) begin
                  r_kind      <= cmd_kind;
                  r_len       <= cmd_len;
                  r_data      <= cmd_data;
                  r_cap       <= 32'd0;
                  r_cmd_ready <= 1'b0;
                  r_state     <= S_PRE;
                  r_step      <= 6'd0;
                  r_phase     <= 1'b0;
                  r_div       <= c_div_reload;
                  r_tms       <= 1'b1;
               end
            end
            S_PRE: begin
               if (w_fall) begin
                  if (r_step == w_pre_last) begin
                     if (r_kind[1]) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= 32'd0;
                     end else begin
                        r_state <= S_SHIFT;
                        r_step  <= 6'd0;
                        r_tms   <= (r_len == 5'd0);
                        r_tdi   <= r_data[0];
                        r_data  <= {1'b0, r_data[31:1]};
                     end
                  end else begin
                     r_step <= w_step_inc;
                     r_tms  <= (w_step_inc < w_pre_ones);
                  end
               end
            end
            S_SHIFT: begin
               if (w_fall) begin
                  if (r_step == w_len_ext) begin
                     r_state <= S_POST;
                     r_step  <= 6'd0;
                     r_tms   <= 1'b1;
                     r_tdi   <= 1'b0;
                  end else begin
                     r_step <= w_step_inc;
                     r_tms  <= (w_step_inc == w_len_ext);
                     r_tdi  <= r_data[0];
                     r_data <= {1'b0, r_data[31:1]};
                  end
               end
            end
            S_POST: begin
               if (w_fall) begin
                  if (r_step == 6'd1) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= r_cap;
                  end else begin
                     r_step <= 6'd1;
                     r_tms  <= 1'b0;
                  end
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_INIT;
            end
         endcase
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign jtag_TCK   = r_tck;
   assign jtag_TMS   = r_tms;
   assign jtag_TDI   = r_tdi;
   assign jtag_TRSTn = r_trstn;

endmodule

`default_nettype wire

// File: doc/jtag_scan_sequencer.md
Name: jtag_scan_sequencer

Overview:
- Synthesizable JTAG master that turns IR/DR scan commands into TCK/TMS/TDI waveforms and captures TDO.
- Walks the IEEE 1149.1 TAP state machine from Run-Test/Idle and back for every command.
- Returns the captured TDO bits on a valid/ready response channel.
- Drives the same jtag_TCK/TMS/TDI/TRSTn/TDO pin set as the simulation JTAG driver, so a bench can swap one for the other in front of the debug transport module.

Parameters:
- TCK_DIV, 4: clock cycles per TCK half-period; legal range 1..255.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_kind  in  2  0 = DR scan, 1 = IR scan, 2 = TAP reset, 3 = treated as TAP reset.
- cmd_len  in  5  scan length minus 1 (L encodes L+1 bits, 1..32); ignored for TAP reset.
- cmd_data  in  32  TDI bits, bit 0 shifted first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accept.
- rsp_data  out  32  captured TDO; bit i sampled with TDI bit i; bits at and above the scan length are 0; 0 for TAP reset.
- jtag_TCK  out  1  test clock.
- jtag_TMS  out  1  test mode select.
- jtag_TDI  out  1  test data in.
- jtag_TRSTn  out  1  TAP reset, active-low.
- jtag_TDO  in  1  test data out from the target.

Behaviour:
- Reset values: jtag_TCK=0, jtag_TMS=1, jtag_TDI=0, jtag_TRSTn=0, cmd_ready=0, rsp_valid=0, rsp_data=0. State=INIT.
- Reset mid-operation abandons the scan immediately; no response is produced.
- TCK timing:
  - One TCK period ("step") = 2*TCK_DIV clocks: TCK_DIV low, then TCK_DIV high.
  - TMS/TDI update only on the clock edge that drives TCK 1->0, or at step start when TCK is already low.
  - TDO is registered on the clock edge that drives TCK 0->1.
  - TCK stays low when no step is running.
- States: INIT, IDLE, PRE, SHIFT, POST, RESP.
- INIT:
  - Hold TRSTn=0 for one step time (2*TCK_DIV clocks) with TCK low.
  - Then TRSTn=1 and run 6 steps with TMS=1,1,1,1,1,0 (Test-Logic-Reset, then Run-Test/Idle).
  - Then go to IDLE.
- IDLE: cmd_ready=1, TMS=0, TCK low. A cmd_valid&cmd_ready handshake latches kind, len and data and enters PRE in the same cycle.
- PRE TMS sequence: DR = 1,0,0 (Select-DR, Capture-DR, Shift-DR). IR = 1,1,0,0.
- TAP reset command: PRE emits TMS=1 x5 then 0, then goes directly to RESP.
- SHIFT:
  - L+1 steps; step i drives TDI=data[i] and samples TDO into capture bit i.
  - TMS=0 on every step except the last, which uses TMS=1 (Exit1).
- POST: 2 steps with TMS=1,0 (Update, Run-Test/Idle).
- Step totals: DR = N+5 TCK rising edges, IR = N+6, TAP reset = 6, where N=L+1.
- RESP:
  - rsp_valid=1 and rsp_data holds the capture register (zero-extended).
  - Holds stable until rsp_ready; the handshake returns the block to IDLE.
  - cmd_ready=0 throughout, and TCK is idle-low.
- cmd_ready is 0 in every state except IDLE; cmd_valid outside IDLE is ignored.
- TDI returns to 0 in POST and in IDLE.
- TRSTn stays 1 after INIT; a TAP reset command uses TMS only.
- Counters:
  - Step counter: 6 bits.
  - Divider: 8 bits, reloads to TCK_DIV-1 at each half-period.
  - No wrap-around is permitted; the step count is bounded by the length field.

Test Plan:
- Reset release, TCK_DIV=2: TRSTn low 4 clocks; 6 TCK rises with TMS=1,1,1,1,1,0; cmd_ready rises afterward; TCK high/low phases are each 2 clocks.
- DR scan, cmd_len=7, cmd_data=0xA5, TDO looped to TDI: 13 TCK rises; TMS = 1,0,0,0x7,1,1,0; TDI in shift = 1,0,1,0,0,1,0,1; rsp_data=0x000000A5.
- IR scan, cmd_len=4, data=0x01, TDO tied 1: 11 TCK rises; TMS begins 1,1,0,0; rsp_data=0x0000001F.
- Full-width DR scan, cmd_len=31, data=0xDEADBEEF, loopback: rsp_data=0xDEADBEEF; 37 TCK rises.
- rsp_ready held 0 for 20 clocks after rsp_valid: rsp_valid/rsp_data stable, cmd_ready=0, no TCK edges; rsp_ready=1 -> IDLE next cycle.
- Reset asserted mid-SHIFT: outputs return to reset values asynchronously; after release the INIT sequence repeats; no stale rsp_valid.
